// File: rtl/cal_pkg.sv
// -----------------------------------------------------------------------------
// cal_pkg
// Shared calendar types and helpers for the date counter, the load validity
// checker and the downstream day-of-year calculator.
//   day_t / month_t / year_t : 6 / 4 / 11-bit unsigned date fields
//   MONTH_LEN                : non-leap month lengths, January first
//   is_leap()                : Gregorian leap rule (year 0 counts as leap)
//   days_in_month()          : month length; 0 for a month outside 1..12
//   zeller_dow()             : day of week (0 = Sunday) of a date
// -----------------------------------------------------------------------------
package cal_pkg;

  typedef logic [5:0]  day_t;
  typedef logic [3:0]  month_t;
  typedef logic [10:0] year_t;

  localparam day_t MONTH_LEN [12] = '{
    6'd31, 6'd28, 6'd31, 6'd30, 6'd31, 6'd30,
    6'd31, 6'd31, 6'd30, 6'd31, 6'd30, 6'd31
  };

  function automatic logic is_leap(year_t y);
    return ((y % 11'd400) == 11'd0) ||
           (((y % 11'd4) == 11'd0) && ((y % 11'd100) != 11'd0));
  endfunction

  function automatic day_t days_in_month(month_t m, logic leap);
    month_t idx;
    day_t   len;
    idx = m - 4'd1;
    len = 6'd0;
    if (m >= 4'd1 && m <= 4'd12) begin
      len = MONTH_LEN[idx];
      if (m == 4'd2 && leap) len = len + 6'd1;
    end
    return len;
  endfunction

  // Zeller's congruence gives 0 = Saturday. January and February count as
  // months 13/14 of the previous year; 400 is added to the year first so
  // that year 0 has a non-negative predecessor (the Gregorian weekday
  // pattern repeats exactly every 400 years).
  function automatic logic [2:0] zeller_dow(day_t d, month_t m, year_t y);
    int unsigned mm, yy, k, j, h;
    mm = (m < 4'd3) ? 32'(m) + 32'd12 : 32'(m);
    yy = 32'(y) + 32'd400 - ((m < 4'd3) ? 32'd1 : 32'd0);
    k  = yy % 32'd100;
    j  = yy / 32'd100;
    h  = (32'(d) + (32'd13 * (mm + 32'd1)) / 32'd5 + k + k / 32'd4 +
          j / 32'd4 + 32'd5 * j) % 32'd7;
    return 3'((h + 32'd6) % 32'd7);
  endfunction

endpackage

// File: rtl/cal_date_check.sv
// -----------------------------------------------------------------------------
// cal_date_check
// Combinational legality check of a candidate date. The leap status used for
// February comes from the candidate year itself.
//   day   in : candidate day of month
//   month in : candidate month
//   year  in : candidate year
//   ok    out: 1 when month is 1..12 and day is 1..length of that month
// -----------------------------------------------------------------------------
module cal_date_check
  import cal_pkg::*;
(
  input  logic [5:0]  day,
  input  logic [3:0]  month,
  input  logic [10:0] year,
  output logic        ok
);

  day_t max_day;

  // days_in_month() returns 0 for an illegal month, so the day range test
  // rejects months 0 and 13..15 on its own.
  assign max_day = days_in_month(month, is_leap(year));
  assign ok      = (day != 6'd0) && (day <= max_day);

endmodule

// File: rtl/calendar_date_counter.sv
// -----------------------------------------------------------------------------
// calendar_date_counter
// Registered Gregorian date counter: advances one day per day_tick, accepts
// validated software loads, and feeds the day-of-year calculator.
// Optional feature macro: CAL_DOW_EN adds the day_of_week register and port.
//   clk         in : clock, all state on the rising edge
//   reset       in : synchronous, active-high
//   day_tick    in : advance the date by one day
//   load        in : load load_day/load_month/load_year if legal (beats tick)
//   load_day/load_month/load_year in : date to load
//   dayOfMonth/month/year out : current date
//   leap        out: current year is a leap year (combinational)
//   date_upd    out: pulse after a tick or an accepted load
//   load_err    out: pulse after a rejected load
//   year_wrap   out: pulse after the year rolled from 2047 to 0
//   day_of_week out: 0 = Sunday (CAL_DOW_EN only)
// -----------------------------------------------------------------------------
module calendar_date_counter
  import cal_pkg::*;
#(
  parameter int unsigned RESET_YEAR = 2000,
  parameter int unsigned RESET_DOW  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        day_tick,
  input  logic        load,
  input  logic [5:0]  load_day,
  input  logic [3:0]  load_month,
  input  logic [10:0] load_year,
  output logic [5:0]  dayOfMonth,
  output logic [3:0]  month,
  output logic [10:0] year,
  output logic        leap,
  output logic        date_upd,
  output logic        load_err,
  output logic        year_wrap
`ifdef CAL_DOW_EN
  ,
  output logic [2:0]  day_of_week
`endif
);

  localparam year_t RST_YEAR = year_t'(RESET_YEAR);

  logic   load_ok;
  day_t   month_len;
  day_t   day_nxt;
  month_t month_nxt;
  year_t  year_nxt;
  logic   wrap_nxt;

  cal_date_check u_load_check (
    .day   (load_day),
    .month (load_month),
    .year  (load_year),
    .ok    (load_ok)
  );

  assign leap      = is_leap(year);
  assign month_len = days_in_month(month, leap);

  // Date one day after the current one.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    day_nxt   = dayOfMonth;
    month_nxt = month;
    year_nxt  = year;
    wrap_nxt  = 1'b0;
    if (dayOfMonth < month_len) begin
      day_nxt = dayOfMonth + 6'd1;
    end else begin
      day_nxt = 6'd1;
      if (month < 4'd12) begin
        month_nxt = month + 4'd1;
      end else begin
        month_nxt = 4'd1;
        year_nxt  = year + 11'd1;   // 2047 wraps to 0 at 11 bits
        wrap_nxt  = (year == 11'd2047);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      dayOfMonth <= 6'd1;
      month      <= 4'd1;
      year       <= RST_YEAR;
      date_upd   <= 1'b0;
      load_err   <= 1'b0;
      year_wrap  <= 1'b0;
    end else begin
      date_upd  <= 1'b0;
      load_err  <= 1'b0;
      year_wrap <= 1'b0;
      if (load) begin
        // A load always consumes a coincident tick, even when rejected.
        if (load_ok) begin
          dayOfMonth <= load_day;
          month      <= load_month;
          year       <= load_year;
          date_upd   <= 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end else if (day_tick) begin
        dayOfMonth <= day_nxt;
        month      <= month_nxt;
        year       <= year_nxt;
        date_upd   <= 1'b1;
        year_wrap  <= wrap_nxt;
      end
    end
  end

`ifdef CAL_DOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      day_of_week <= 3'(RESET_DOW);
    end else if (load) begin
      if (load_ok) day_of_week <= zeller_dow(load_day, load_month, load_year);
    end else if (day_tick) begin
      day_of_week <= (day_of_week == 3'd6) ? 3'd0 : day_of_week + 3'd1;
    end
  end
`else
  // Keeps the parameter referenced when the weekday feature is compiled out.
  localparam int unsigned unused_reset_dow = RESET_DOW;
`endif

endmodule

// File: tb/tb_calendar_date_counter.sv
// -----------------------------------------------------------------------------
// tb_calendar_date_counter
// Directed self-checking bench for calendar_date_counter. Inputs change on the
// falling edge and outputs are sampled on the falling edge after the rising
// edge that consumed them. Define CAL_DOW_EN to also check day_of_week.
// -----------------------------------------------------------------------------
module tb_calendar_date_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        day_tick = 1'b0;
  logic        load = 1'b0;
  logic [5:0]  load_day = 6'd0;
  logic [3:0]  load_month = 4'd0;
  logic [10:0] load_year = 11'd0;
  logic [5:0]  dayOfMonth;
  logic [3:0]  month;
  logic [10:0] year;
  logic        leap;
  logic        date_upd;
  logic        load_err;
  logic        year_wrap;
`ifdef CAL_DOW_EN
  logic [2:0]  day_of_week;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  calendar_date_counter #(
    .RESET_YEAR (2000),
    .RESET_DOW  (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .day_tick   (day_tick),
    .load       (load),
    .load_day   (load_day),
    .load_month (load_month),
    .load_year  (load_year),
    .dayOfMonth (dayOfMonth),
    .month      (month),
    .year       (year),
    .leap       (leap),
    .date_upd   (date_upd),
    .load_err   (load_err),
    .year_wrap  (year_wrap)
`ifdef CAL_DOW_EN
    ,
    .day_of_week(day_of_week)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_date(input string tag, input int d, input int m, input int y);
    check({tag, ".day"},   32'(dayOfMonth), 32'(d));
    check({tag, ".month"}, 32'(month),      32'(m));
    check({tag, ".year"},  32'(year),       32'(y));
  endtask

  task automatic check_pulses(input string tag, input logic upd, input logic err,
                              input logic wrap);
    check({tag, ".date_upd"},  32'(date_upd),  32'(upd));
    check({tag, ".load_err"},  32'(load_err),  32'(err));
    check({tag, ".year_wrap"}, 32'(year_wrap), 32'(wrap));
  endtask

  task automatic check_dow(input string tag, input int dow);
`ifdef CAL_DOW_EN
    check({tag, ".dow"}, 32'(day_of_week), 32'(dow));
`endif
  endtask

  // One-cycle request; returns on the falling edge after it was consumed.
  task automatic step(input logic do_load, input logic do_tick,
                      input int d, input int m, input int y);
    load       = do_load;
    day_tick   = do_tick;
    load_day   = 6'(d);
    load_month = 4'(m);
    load_year  = 11'(y);
    @(negedge clk);
    load     = 1'b0;
    day_tick = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_date("reset", 1, 1, 2000);
    check("reset.leap", 32'(leap), 32'd1);
    check_pulses("reset", 1'b0, 1'b0, 1'b0);
    check_dow("reset", 6);

    // 366 back-to-back ticks through leap year 2000
    day_tick = 1'b1;
    repeat (366) @(negedge clk);
    day_tick = 1'b0;
    check_date("tick366", 1, 1, 2001);
    check_dow("tick366", 1);
    check("tick366.upd", 32'(date_upd), 32'd1);
    @(negedge clk);
    check("tick366.upd_clear", 32'(date_upd), 32'd0);

    // Plain rollover
    step(1'b1, 1'b0, 28, 2, 2023);
    check_date("ld_2023", 28, 2, 2023);
    check_pulses("ld_2023", 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 0, 0, 0);
    check_date("roll_2023", 1, 3, 2023);
    check_pulses("roll_2023", 1'b1, 1'b0, 1'b0);
    check("roll_2023.leap", 32'(leap), 32'd0);

    // Leap-year rules
    step(1'b1, 1'b0, 28, 2, 2024);
    check_dow("ld_2024", 3);
    step(1'b0, 1'b1, 0, 0, 0);
    check_date("leap_2024a", 29, 2, 2024);
    check_dow("leap_2024a", 4);
    check("leap_2024a.leap", 32'(leap), 32'd1);
    step(1'b0, 1'b1, 0, 0, 0);
    check_date("leap_2024b", 1, 3, 2024);

    step(1'b1, 1'b0, 28, 2, 1900);
    step(1'b0, 1'b1, 0, 0, 0);
    check_date("leap_1900", 1, 3, 1900);
    check("leap_1900.leap", 32'(leap), 32'd0);

    step(1'b1, 1'b0, 28, 2, 2000);
    step(1'b0, 1'b1, 0, 0, 0);
    check_date("leap_2000", 29, 2, 2000);

    // Year wrap
    step(1'b1, 1'b0, 31, 12, 2047);
    check_pulses("ld_2047", 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 0, 0, 0);
    check_date("wrap", 1, 1, 0);
    check_pulses("wrap", 1'b1, 1'b0, 1'b1);
    check("wrap.leap", 32'(leap), 32'd1);
    @(negedge clk);
    check_pulses("wrap_after", 1'b0, 1'b0, 1'b0);

    // Invalid loads leave 1/1/0 untouched
    step(1'b1, 1'b0, 31, 4, 2021);
    check_date("bad_apr31", 1, 1, 0);
    check_pulses("bad_apr31", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("bad_apr31.err_clear", 32'(load_err), 32'd0);
    step(1'b1, 1'b0, 29, 2, 2023);
    check_pulses("bad_feb29", 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 5, 2021);
    check_pulses("bad_day0", 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1, 13, 2021);
    check_pulses("bad_mon13", 1'b0, 1'b1, 1'b0);
    check_date("bad_all", 1, 1, 0);
    // Leap status of the load year, not the current one (year 0 is leap)
    step(1'b1, 1'b0, 29, 2, 2001);
    check_pulses("bad_feb29_2001", 1'b0, 1'b1, 1'b0);

    // Load beats tick
    step(1'b1, 1'b1, 15, 6, 2010);
    check_date("ld_tick", 15, 6, 2010);
    check_pulses("ld_tick", 1'b1, 1'b0, 1'b0);
    check_dow("ld_tick", 2);
    // Rejected load still swallows the tick
    step(1'b1, 1'b1, 31, 6, 2010);
    check_date("badld_tick", 15, 6, 2010);
    check_pulses("badld_tick", 1'b0, 1'b1, 1'b0);
    check_dow("badld_tick", 2);

    // Reset in the middle of a tick stream
    day_tick = 1'b1;
    repeat (3) @(negedge clk);
    check_date("stream", 18, 6, 2010);
    reset = 1'b1;
    @(negedge clk);
    check_date("rst_mid", 1, 1, 2000);
    check_pulses("rst_mid", 1'b0, 1'b0, 1'b0);
    check_dow("rst_mid", 6);
    reset    = 1'b0;
    day_tick = 1'b0;
    @(negedge clk);
    check_pulses("rst_after", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
